// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types, widths and helpers for the instruction fetch controller.
// The PC advance helper wraps modulo the addressable instruction space.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;

  localparam int PC_W        = 14;
  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                 input int unsigned mem_bytes);
    logic [31:0] sum_s;
    sum_s = {{(32-PC_W){1'b0}}, pc} + 32'(INSTR_BYTES);
    sum_s = sum_s % mem_bytes;
    return sum_s[PC_W-1:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_pc_register.sv
// Program counter register: load has priority over advance, otherwise hold.
// Advancing past the last word of instruction memory wraps to address 0.
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned     MEM_BYTES = 1024,
  parameter logic [PC_W-1:0] RESET_PC  = 14'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_value,
  input  logic            advance,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;

  assign pc = pc_r;

  // PC state: reset, redirect/restart load, sequential advance, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= load_value;
    end else if (advance) begin
      pc_r <= pc_advance(pc_r, MEM_BYTES);
    end else begin
      pc_r <= pc_r;
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: drives the combinational instruction memory from the PC and
// registers each returned word toward decode with valid/ready, redirect and halt.
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter int              N         = 32,
  parameter int unsigned     MEM_BYTES = 1024,
  parameter logic [PC_W-1:0] RESET_PC  = 14'd0,
  parameter logic [N-1:0]    HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_address,
  input  logic [N-1:0]    imem_instruction,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            decode_ready,
  output logic [N-1:0]    instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid,
  output logic            halted,
  output logic            busy
);

  fetch_state_t    state_r;
  fetch_state_t    state_next_s;
  logic [N-1:0]    instr_r;
  logic [PC_W-1:0] pc_out_r;
  logic            valid_r;
  logic            halted_r;
  logic            busy_r;

  logic [PC_W-1:0] pc_s;
  logic            pc_load_s;
  logic [PC_W-1:0] pc_load_value_s;
  logic            pc_advance_s;
  logic            out_load_s;
  logic            out_clear_s;
  logic            out_free_s;
  logic [PC_W-1:0] target_s;

  assign imem_address = pc_s;
  assign instr_out    = instr_r;
  assign pc_out       = pc_out_r;
  assign instr_valid  = valid_r;
  assign halted       = halted_r;
  assign busy         = busy_r;

  // Redirect targets are always word aligned
  assign target_s   = branch_target & 14'h3FFC;
  assign out_free_s = ~valid_r | decode_ready;

  pc_register #(
    .MEM_BYTES (MEM_BYTES),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load_s),
    .load_value (pc_load_value_s),
    .advance    (pc_advance_s),
    .pc         (pc_s)
  );

  // Next-state and per-cycle action decode; redirect outranks everything
  always_comb begin
    state_next_s    = state_r;
    pc_load_s       = 1'b0;
    pc_load_value_s = pc_s;
    pc_advance_s    = 1'b0;
    out_load_s      = 1'b0;
    out_clear_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          pc_load_s       = 1'b1;
          pc_load_value_s = RESET_PC;
          state_next_s    = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          out_clear_s     = 1'b1;
          pc_load_s       = 1'b1;
          pc_load_value_s = target_s;
        end else if (out_free_s) begin
          out_load_s = 1'b1;
          if (imem_instruction == HALT_WORD) begin
            state_next_s = HALT;
          end else begin
            pc_advance_s = 1'b1;
          end
        end else begin
          state_next_s = FETCH;
        end
      end
      HALT: begin
        if (branch_taken) begin
          out_clear_s     = 1'b1;
          pc_load_s       = 1'b1;
          pc_load_value_s = target_s;
          state_next_s    = FETCH;
        end else if (start) begin
          out_clear_s     = 1'b1;
          pc_load_s       = 1'b1;
          pc_load_value_s = RESET_PC;
          state_next_s    = FETCH;
        end else if (valid_r && decode_ready) begin
          out_clear_s = 1'b1;
        end else begin
          state_next_s = HALT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register with status flags registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      halted_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == HALT);
      busy_r   <= (state_next_s == FETCH);
    end
  end

  // Output register toward decode; a flush drops the held word
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r  <= {N{1'b0}};
      pc_out_r <= 14'd0;
      valid_r  <= 1'b0;
    end else if (out_clear_s) begin
      instr_r  <= instr_r;
      pc_out_r <= pc_out_r;
      valid_r  <= 1'b0;
    end else if (out_load_s) begin
      instr_r  <= imem_instruction;
      pc_out_r <= pc_s;
      valid_r  <= 1'b1;
    end else begin
      instr_r  <= instr_r;
      pc_out_r <= pc_out_r;
      valid_r  <= valid_r;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench: two controllers (RESET_PC 0 and 1020) share stimulus and a
// behavioural combinational little-endian instruction memory.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        branch_taken = 1'b0;
  logic [13:0] branch_target = 14'd0;
  logic        decode_ready = 1'b0;

  logic [13:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] instr_out;
  logic [13:0] pc_out;
  logic        instr_valid, halted, busy;

  logic [13:0] w_imem_address;
  logic [31:0] w_imem_instruction;
  logic [31:0] w_instr_out;
  logic [13:0] w_pc_out;
  logic        w_instr_valid, w_halted, w_busy;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instruction   = mem[imem_address[13:2]];
  assign w_imem_instruction = mem[w_imem_address[13:2]];

  instruction_fetch_controller #(
    .N(32), .MEM_BYTES(1024), .RESET_PC(14'd0), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_address(imem_address), .imem_instruction(imem_instruction),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .decode_ready(decode_ready), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .halted(halted), .busy(busy)
  );

  instruction_fetch_controller #(
    .N(32), .MEM_BYTES(1024), .RESET_PC(14'd1020), .HALT_WORD(32'hFFFF_FFFF)
  ) dut_wrap (
    .clk(clk), .rst(rst), .start(start),
    .imem_address(w_imem_address), .imem_instruction(w_imem_instruction),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .decode_ready(decode_ready), .instr_out(w_instr_out), .pc_out(w_pc_out),
    .instr_valid(w_instr_valid), .halted(w_halted), .busy(w_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; branch_taken = 1'b0; branch_target = 14'd0; decode_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (halted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got halted=%b busy=%b exp 0 0", halted, busy); end
    checks++; if (instr_out !== 32'd0 || pc_out !== 14'd0) begin errors++; $display("FAIL reset_out got %h/%h exp 0/0", instr_out, pc_out); end
    checks++; if (imem_address !== 14'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_address); end
    checks++; if (w_imem_address !== 14'd1020) begin errors++; $display("FAIL reset_wrap_addr got %0d exp 1020", w_imem_address); end
  endtask

  // Stream three words, then hit the halt word at 0x0C, consume it, restart
  task automatic test_fetch_and_halt();
    logic [31:0] exp_w [0:2];
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222; exp_w[2] = 32'h3333_3333;
    do_reset();
    decode_ready = 1'b1;
    pulse_start();
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0 || imem_address !== 14'd0) begin errors++; $display("FAIL start_state got busy=%b valid=%b addr=%h exp 1 0 0", busy, instr_valid, imem_address); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_out !== exp_w[i] || pc_out !== 14'(4*i) || instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_%0d got %h/%h/%b exp %h/%h/1", i, instr_out, pc_out, instr_valid, exp_w[i], 14'(4*i)); end
    end
    step();
    checks++; if (instr_out !== 32'hFFFF_FFFF || pc_out !== 14'h00C || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_word got %h/%h/%b exp ffffffff/00c/1", instr_out, pc_out, instr_valid); end
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || imem_address !== 14'h00C) begin errors++; $display("FAIL halt_state got halted=%b busy=%b addr=%h exp 1 0 00c", halted, busy, imem_address); end
    step();
    checks++; if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_address !== 14'h00C) begin errors++; $display("FAIL halt_consumed got valid=%b halted=%b addr=%h exp 0 1 00c", instr_valid, halted, imem_address); end
    pulse_start();
    checks++; if (busy !== 1'b1 || halted !== 1'b0 || imem_address !== 14'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL restart got busy=%b halted=%b addr=%h valid=%b exp 1 0 0 0", busy, halted, imem_address, instr_valid); end
    step();
    checks++; if (instr_out !== 32'h1111_1111 || pc_out !== 14'd0 || instr_valid !== 1'b1) begin errors++; $display("FAIL restart_fetch got %h/%h/%b exp 11111111/0/1", instr_out, pc_out, instr_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    decode_ready = 1'b1;
    pulse_start();
    step();
    step();
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_out !== 32'h2222_2222 || pc_out !== 14'd4 || instr_valid !== 1'b1 || imem_address !== 14'd8) begin errors++; $display("FAIL stall_%0d got %h/%h/%b addr=%h exp 22222222/4/1 addr=8", i, instr_out, pc_out, instr_valid, imem_address); end
    end
    decode_ready = 1'b1;
    step();
    checks++; if (instr_out !== 32'h3333_3333 || pc_out !== 14'd8 || instr_valid !== 1'b1) begin errors++; $display("FAIL release got %h/%h/%b exp 33333333/8/1", instr_out, pc_out, instr_valid); end
  endtask

  task automatic test_branch();
    do_reset();
    decode_ready = 1'b1;
    pulse_start();
    step();
    branch_taken = 1'b1; branch_target = 14'h0023;
    step();
    branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_address !== 14'h0020 || busy !== 1'b1) begin errors++; $display("FAIL branch_flush got valid=%b addr=%h busy=%b exp 0 0020 1", instr_valid, imem_address, busy); end
    step();
    checks++; if (instr_out !== 32'hA5A5_0020 || pc_out !== 14'h0020 || instr_valid !== 1'b1) begin errors++; $display("FAIL branch_target got %h/%h/%b exp a5a50020/0020/1", instr_out, pc_out, instr_valid); end
  endtask

  // Redirect and start together while halted: the redirect wins
  task automatic test_branch_in_halt();
    do_reset();
    decode_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_reached got %b exp 1", halted); end
    branch_taken = 1'b1; branch_target = 14'h0020; start = 1'b1;
    step();
    branch_taken = 1'b0; start = 1'b0;
    checks++; if (imem_address !== 14'h0020 || busy !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_branch got addr=%h busy=%b halted=%b valid=%b exp 0020 1 0 0", imem_address, busy, halted, instr_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    decode_ready = 1'b1;
    pulse_start();
    step();
    checks++; if (w_pc_out !== 14'd1020 || w_instr_out !== 32'hDEAD_03FC || w_instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_last got %0d/%h/%b exp 1020/dead03fc/1", w_pc_out, w_instr_out, w_instr_valid); end
    step();
    checks++; if (w_pc_out !== 14'd0 || w_instr_out !== 32'h1111_1111) begin errors++; $display("FAIL wrap_zero got %0d/%h exp 0/11111111", w_pc_out, w_instr_out); end
    step();
    checks++; if (w_pc_out !== 14'd4 || w_instr_out !== 32'h2222_2222) begin errors++; $display("FAIL wrap_four got %0d/%h exp 4/22222222", w_pc_out, w_instr_out); end
  endtask

  task automatic test_sync_reset();
    do_reset();
    decode_ready = 1'b1;
    pulse_start();
    step();
    #3;
    rst = 1'b1; branch_taken = 1'b1; branch_target = 14'h0020;
    #1;
    checks++; if (instr_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_between_edges got valid=%b busy=%b exp 1 1", instr_valid, busy); end
    @(posedge clk);
    #1;
    rst = 1'b0; branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_mid_state got valid=%b busy=%b halted=%b exp 0 0 0", instr_valid, busy, halted); end
    checks++; if (imem_address !== 14'd0 || instr_out !== 32'd0 || pc_out !== 14'd0) begin errors++; $display("FAIL rst_mid_pc got addr=%h out=%h pc_out=%h exp 0 0 0", imem_address, instr_out, pc_out); end
    step();
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_address !== 14'd0) begin errors++; $display("FAIL rst_idle_hold got busy=%b valid=%b addr=%h exp 0 0 0", busy, instr_valid, imem_address); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0000;
    mem[0]   = 32'h1111_1111;
    mem[1]   = 32'h2222_2222;
    mem[2]   = 32'h3333_3333;
    mem[3]   = 32'hFFFF_FFFF;
    mem[8]   = 32'hA5A5_0020;
    mem[255] = 32'hDEAD_03FC;

    test_reset();
    test_fetch_and_halt();
    test_backpressure();
    test_branch();
    test_branch_in_halt();
    test_wrap();
    test_sync_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
